uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter among NUM_REQ byte requesters using round-robin arbitration.
//  - Accepts one byte from the winning requester.
//  - Issues a single-cycle enable to the UART Tx.
//  - Holds tx_data stable while the frame is in flight (Tx and the loopback Rx compare against it).
//  - Waits for the UART busy flag to rise and then fall before granting again.
//  Sits between the client logic and the UART top in the same clock domain.
// PARAMETERS
//  NUM_REQ       4   number of requesters (2..8)
//  DATA_WIDTH    8   payload width; must match the UART INPUT_DATA_WIDTH
//  BUSY_TIMEOUT  64  max cycles from enable pulse to tx_busy high before an error is flagged
// PORTS
//  clk            in   1                   system clock; single clock domain
//  reset          in   1                   synchronous, active-high reset
//  req_valid      in   NUM_REQ             requester i has a byte pending
//  req_data       in   NUM_REQ*DATA_WIDTH  byte for requester i, in slice [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready      out  NUM_REQ             one-cycle accept pulse; at most one bit set
//  tx_enable      out  1                   to UART enable; one-cycle pulse
//  tx_data        out  DATA_WIDTH          to UART i_data; registered
//  tx_busy        in   1                   from UART o_busy
//  grant_id       out  $clog2(NUM_REQ)     index of the requester owning the current frame
//  active         out  1                   high from accept until tx_busy falls
//  timeout_err    out  1                   sticky; cleared only by reset
// BEHAVIOUR
//  Reset values (sync reset, active-high): req_ready=0, tx_enable=0, tx_data=0, grant_id=0,
//    active=0, timeout_err=0, rr_ptr=0, state=IDLE. Reset mid-frame aborts the frame; no req_ready is replayed.
//  FSM: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//  IDLE:
//    - If any req_valid is set and tx_busy=0, pick the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
//    - In the same cycle: pulse req_ready[k], latch req_data slice k into tx_data, set grant_id=k and active=1.
//    - Set rr_ptr=(k+1) mod NUM_REQ.
//    - If tx_busy=1 in IDLE, no grant is made.
//  ISSUE: tx_enable=1 for exactly one cycle, then WAIT_BUSY. Latency from req_valid seen in IDLE to tx_enable = 2 cycles.
//  WAIT_BUSY:
//    - Stays until tx_busy=1, then goes to WAIT_DONE.
//    - Counts cycles. When the count reaches BUSY_TIMEOUT, sets timeout_err=1, clears active, returns to IDLE.
//    - tx_enable stays 0; no re-pulse.
//  WAIT_DONE: stays while tx_busy=1. On tx_busy=0, clears active and returns to IDLE.
//  Back-to-back frames: a grant is legal in the first IDLE cycle after tx_busy falls.
//  Invariants:
//    - tx_enable is never 1 while tx_busy=1 or reset=1.
//    - tx_data and grant_id change only on an accept.
//    - req_ready is never asserted outside IDLE.
//  Requester rules: req_valid and req_data must be held until req_ready. Dropping req_valid earlier is legal and simply loses arbitration.
//  Fairness: with all requesters valid, grants cycle 0,1,..,NUM_REQ-1,0 with no skips.
//  Width rules: the round-robin pick and rr_ptr use modulo-NUM_REQ wrap.
//    The timeout counter is $clog2(BUSY_TIMEOUT+1) bits and saturates.
// CONFIGURATION
//  UART_ARB_TAG_EN defined:
//    - Each accepted byte is preceded by a tag frame {1'b1, grant_id} zero-extended to DATA_WIDTH.
//    - Extra states TAG_ISSUE, TAG_BUSY and TAG_DONE run before ISSUE, with the same busy, timeout and stability rules.
//    - tx_data holds the tag during the tag frame and is loaded with the payload only after tx_busy falls.
//    - active spans both frames.
//  UART_ARB_TAG_EN undefined: payload frames only, exactly as above.
// STRUCTURE
//  uart_arb_pkg holds:
//    - the state encoding localparams;
//    - the TAG_MARKER bit position;
//    - the function clog2_min1(n), which returns at least 1.
//  Sub-module rr_pick: combinational round-robin picker.
//    Inputs: req[NUM_REQ], ptr. Outputs: any, idx.
//    Instantiated once. FSM, counters and registers stay in uart_tx_arbiter.
// TESTING
//  1. Single requester: req_valid=4'b0001, data 8'hA5, UART loopback.
//     Expect: req_ready[0] pulse, tx_enable 2 cycles later, tx_data=8'hA5 until busy falls,
//     received_data=8'hA5, no rx_error.
//  2. All valid, data 8'h10..8'h13: grant order 0,1,2,3,0.
//     Expect: one tx_enable per frame, never while tx_busy=1.
//  3. Requesters 1 and 3 valid, rr_ptr=2: grant 3 first, then 1. Requester 2 is never granted.
//  4. tx_busy tied 0 after enable: timeout_err=1 exactly BUSY_TIMEOUT cycles after the ISSUE cycle.
//     Expect: active=0 and the FSM back in IDLE.
//  5. Reset asserted in WAIT_DONE: all outputs at reset values on the next cycle.
//     Expect: the next grant starts at requester 0.
//  6. With UART_ARB_TAG_EN, requester 2 sends 8'h3C: frames observed are 8'h82 then 8'h3C, with active high across both.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the round-robin UART transmit arbiter.
//   arb_state_t         FSM state encoding (tag states are used only when
//                       UART_ARB_TAG_EN is defined)
//   TAG_MARKER_FROM_MSB distance of the tag marker bit below the payload MSB
//   clog2_min1()        $clog2 that never returns less than 1, for index widths
package uart_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_TAG_ISSUE = 3'd4,
        ST_TAG_BUSY  = 3'd5,
        ST_TAG_DONE  = 3'd6
    } arb_state_t;

    // Tag frames carry a marker bit at the payload MSB.
    localparam int TAG_MARKER_FROM_MSB = 0;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req  : request vector, one bit per requester
//   ptr  : highest-priority index for this pick
//   any  : at least one request is set
//   idx  : first set request at or after ptr, wrapping modulo NUM_REQ
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               any,
    output logic [IW-1:0]      idx
);

    always_comb begin
        int c;
        c   = 0;
        any = |req;
        idx = '0;
        // Walk from the farthest offset back to ptr so the nearest hit wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            c = int'(ptr) + i;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (req[IW'(c)]) idx = IW'(c);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters, round-robin.
// A winner is accepted with a one-cycle req_ready, its byte is registered on
// tx_data, tx_enable pulses once, and the arbiter waits for tx_busy to rise
// and fall before granting again. A missing busy rise sets a sticky error.
//   clk, reset   clock, synchronous active-high reset
//   req_valid    per-requester pending flag
//   req_data     per-requester byte, slice [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    one-cycle accept pulse (combinational, at most one bit)
//   tx_enable    one-cycle start pulse to the UART
//   tx_data      registered byte for the UART, stable through the frame
//   tx_busy      UART busy flag
//   grant_id     requester owning the current frame
//   active       accept through end of frame
//   timeout_err  sticky: busy never rose within BUSY_TIMEOUT cycles
// Optional feature macro: UART_ARB_TAG_EN -- send a {1, grant_id} tag frame
// ahead of every payload frame.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             tx_enable,
    output logic [DATA_WIDTH-1:0]            tx_data,
    input  logic                             tx_busy,
    output logic [clog2_min1(NUM_REQ)-1:0]   grant_id,
    output logic                             active,
    output logic                             timeout_err
);

    localparam int IW = clog2_min1(NUM_REQ);
    localparam int CW = clog2_min1(BUSY_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(BUSY_TIMEOUT);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (v == IW'(NUM_REQ - 1)) ? '0 : v + 1'b1;
    endfunction

    arb_state_t             state_q, state_n;
    logic [DATA_WIDTH-1:0]  tx_data_n;
    logic [IW-1:0]          grant_n, rr_ptr, rr_n;
    logic                   active_n, err_n, en_q, en_n;
    logic [CW-1:0]          cnt_q, cnt_n, cnt_inc;
    logic [NUM_REQ-1:0]     ready_raw;
    logic                   pick_any;
    logic [IW-1:0]          pick_idx;
    logic [DATA_WIDTH-1:0]  pick_data;

`ifdef UART_ARB_TAG_EN
    logic [DATA_WIDTH-1:0]  payload_q, payload_n;

    function automatic logic [DATA_WIDTH-1:0] tag_of(input logic [IW-1:0] id);
        logic [DATA_WIDTH-1:0] t;
        t = '0;
        t[IW-1:0] = id;
        t[DATA_WIDTH-1-TAG_MARKER_FROM_MSB] = 1'b1;
        return t;
    endfunction
`endif

    rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign pick_data = req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
    assign cnt_inc   = sat_inc(cnt_q);

    // Gating keeps the handshake and start pulse quiet during reset and
    // never lets a start pulse overlap a busy UART.
    assign req_ready = ready_raw & {NUM_REQ{~reset}};
    assign tx_enable = en_q & ~tx_busy & ~reset;

    always_comb begin
        state_n   = state_q;
        tx_data_n = tx_data;
        grant_n   = grant_id;
        active_n  = active;
        err_n     = timeout_err;
        rr_n      = rr_ptr;
        cnt_n     = cnt_q;
        en_n      = 1'b0;
        ready_raw = '0;
`ifdef UART_ARB_TAG_EN
        payload_n = payload_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any && !tx_busy) begin
                    ready_raw[pick_idx] = 1'b1;
                    grant_n  = pick_idx;
                    active_n = 1'b1;
                    rr_n     = wrap_inc(pick_idx);
                    cnt_n    = '0;
`ifdef UART_ARB_TAG_EN
                    payload_n = pick_data;
                    tx_data_n = tag_of(pick_idx);
                    state_n   = ST_TAG_ISSUE;
`else
                    tx_data_n = pick_data;
                    state_n   = ST_ISSUE;
`endif
                end
            end
            ST_ISSUE: begin
                en_n    = 1'b1;
                cnt_n   = cnt_inc;
                state_n = ST_WAIT_BUSY;
            end
            // The counter runs from the issue cycle so the error lands
            // BUSY_TIMEOUT cycles after it.
            ST_WAIT_BUSY: begin
                cnt_n = cnt_inc;
                if (tx_busy) begin
                    state_n = ST_WAIT_DONE;
                end else if (cnt_inc >= CNT_LIMIT) begin
                    err_n    = 1'b1;
                    active_n = 1'b0;
                    state_n  = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    active_n = 1'b0;
                    state_n  = ST_IDLE;
                end
            end
`ifdef UART_ARB_TAG_EN
            ST_TAG_ISSUE: begin
                en_n    = 1'b1;
                cnt_n   = cnt_inc;
                state_n = ST_TAG_BUSY;
            end
            ST_TAG_BUSY: begin
                cnt_n = cnt_inc;
                if (tx_busy) begin
                    state_n = ST_TAG_DONE;
                end else if (cnt_inc >= CNT_LIMIT) begin
                    err_n    = 1'b1;
                    active_n = 1'b0;
                    state_n  = ST_IDLE;
                end
            end
            // Payload replaces the tag only once the tag frame has finished.
            ST_TAG_DONE: begin
                if (!tx_busy) begin
                    tx_data_n = payload_q;
                    cnt_n     = '0;
                    state_n   = ST_ISSUE;
                end
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tx_data     <= '0;
            grant_id    <= '0;
            active      <= 1'b0;
            timeout_err <= 1'b0;
            rr_ptr      <= '0;
            cnt_q       <= '0;
            en_q        <= 1'b0;
`ifdef UART_ARB_TAG_EN
            payload_q   <= '0;
`endif
        end else begin
            state_q     <= state_n;
            tx_data     <= tx_data_n;
            grant_id    <= grant_n;
            active      <= active_n;
            timeout_err <= err_n;
            rr_ptr      <= rr_n;
            cnt_q       <= cnt_n;
            en_q        <= en_n;
`ifdef UART_ARB_TAG_EN
            payload_q   <= payload_n;
`endif
        end
    end

endmodule
